pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer for the 16-bit CPU datapath.
- Sits directly downstream of the 16-bit incrementor: pc+1 is its next-sequential address, and the unit holds PC.
- Issues req/ack fetches to instruction memory and presents each fetched word to decode on a valid/ready handshake.
- Supports jump/branch redirection via load.

---
 rtl/pc_fetch_unit.sv | 137 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// Holds PC, issues req/ack fetches to instruction memory and hands each
// fetched word to decode over a valid/ready handshake. load redirects PC.
// Optional macro PC_FETCH_PERF_CNT_EN adds a saturating fetch_count output
// counting words accepted by decode.
module pc_fetch_unit #(
  parameter int                 WIDTH     = 16,
  parameter logic [WIDTH-1:0]   RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] pc,
  output logic             wrap
`ifdef PC_FETCH_PERF_CNT_EN
  ,
  output logic [WIDTH-1:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] instr_reg;
  logic [WIDTH-1:0] instr_pc_reg;
  logic             imem_req_reg;
  logic             instr_valid_reg;
  logic             wrap_reg;

  // Next sequential address, unsigned modulo 2^WIDTH.
  assign pc_next = pc_reg + {{(WIDTH-1){1'b0}}, 1'b1};

  // Sequencer: PC, captured instruction and handshake flags all update here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= RESET_VEC;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
      imem_req_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
      wrap_reg        <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (load) pc_reg <= load_addr;
          if (en) begin
            state_reg    <= ST_REQ;
            imem_req_reg <= 1'b1;
          end
        end
        ST_REQ: begin
          if (imem_ack && !load) begin
            instr_reg       <= imem_data;
            instr_pc_reg    <= pc_reg;
            pc_reg          <= pc_next;
            wrap_reg        <= (pc_reg == {WIDTH{1'b1}});
            state_reg       <= ST_HOLD;
            imem_req_reg    <= 1'b0;
            instr_valid_reg <= 1'b1;
          end else if (imem_ack) begin
            // Fetch completed but is superseded by the redirect.
            pc_reg       <= load_addr;
            state_reg    <= en ? ST_REQ : ST_IDLE;
            imem_req_reg <= en;
          end else if (load) begin
            // Drop req for one cycle so the address may legally change.
            pc_reg       <= load_addr;
            state_reg    <= ST_FLUSH;
            imem_req_reg <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (load) pc_reg <= load_addr;
          state_reg    <= en ? ST_REQ : ST_IDLE;
          imem_req_reg <= en;
        end
        ST_HOLD: begin
          if (load) pc_reg <= load_addr;
          if (instr_ready || load) begin
            instr_valid_reg <= 1'b0;
            state_reg       <= en ? ST_REQ : ST_IDLE;
            imem_req_reg    <= en;
          end
        end
        default: begin
          state_reg       <= ST_IDLE;
          imem_req_reg    <= 1'b0;
          instr_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = pc_reg;
  assign instr_valid = instr_valid_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign pc          = pc_reg;
  assign wrap        = wrap_reg;

`ifdef PC_FETCH_PERF_CNT_EN
  logic [WIDTH-1:0] fetch_count_reg;

  // Saturating count of words actually accepted by decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count_reg <= '0;
    end else if (instr_valid_reg && instr_ready &&
                 (fetch_count_reg != {WIDTH{1'b1}})) begin
      fetch_count_reg <= fetch_count_reg + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign fetch_count = fetch_count_reg;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] load_addr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [15:0] pc;
  logic        wrap;
`ifdef PC_FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model: fetch address, whether a request or a held word is
  // pending, the last captured word, wrap pulse and accepted-word count.
  logic [15:0] m_pc    = 16'h0000;
  logic        m_req   = 1'b0;
  logic        m_valid = 1'b0;
  logic [15:0] m_instr = 16'h0000;
  logic [15:0] m_ipc   = 16'h0000;
  logic        m_wrap  = 1'b0;
  logic [15:0] m_cnt   = 16'h0000;

  pc_fetch_unit #(.WIDTH(16), .RESET_VEC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .load_addr  (load_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .pc         (pc),
    .wrap       (wrap)
`ifdef PC_FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model.
  task automatic compare_all();
    chk("imem_req",    32'(imem_req),    32'(m_req));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("imem_addr",   32'(imem_addr),   32'(m_pc));
    chk("pc",          32'(pc),          32'(m_pc));
    chk("instr",       32'(instr),       32'(m_instr));
    chk("instr_pc",    32'(instr_pc),    32'(m_ipc));
    chk("wrap",        32'(wrap),        32'(m_wrap));
`ifdef PC_FETCH_PERF_CNT_EN
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
`endif
  endtask

  // One clock: drive inputs (memory returns addr^A5A5), advance the model
  // at the edge, then compare on the falling edge.
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [15:0] la, input logic a, input logic rd);
    logic [15:0] data;
    data        = m_pc ^ 16'hA5A5;
    rst_n       = r;
    en          = e;
    load        = l;
    load_addr   = la;
    imem_ack    = a;
    imem_data   = data;
    instr_ready = rd;
    @(posedge clk);
    if (!r) begin
      m_pc = 16'h0000; m_req = 1'b0; m_valid = 1'b0;
      m_instr = 16'h0000; m_ipc = 16'h0000; m_wrap = 1'b0; m_cnt = 16'h0000;
    end else begin
      m_wrap = 1'b0;
      if (m_valid && rd && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_req) begin
        if (a && !l) begin
          m_instr = data;
          m_ipc   = m_pc;
          m_wrap  = (m_pc == 16'hFFFF);
          m_pc    = m_pc + 16'd1;
          m_req   = 1'b0;
          m_valid = 1'b1;
        end else if (l) begin
          m_pc  = la;
          // A completed-but-redirected fetch may reissue at once; an
          // abandoned one costs a one-cycle gap with req low.
          m_req = a ? e : 1'b0;
        end
      end else begin
        if (l) m_pc = la;
        if (m_valid) begin
          if (rd || l) begin
            m_valid = 1'b0;
            m_req   = e;
          end
        end else begin
          m_req = e;
        end
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int acc;
    int nwrap;
    logic [15:0] exp_pc;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_addr = 16'h0000;
    imem_ack = 1'b0; imem_data = 16'h0000; instr_ready = 1'b0;
    @(negedge clk);

    // Reset state
    step(0, 0, 0, 16'h0000, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 0);
    chk("rst_pc",    32'(pc),          32'h0);
    chk("rst_req",   32'(imem_req),    32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);

    // Sequential fetch of four words
    acc = 0;
    for (int i = 0; i < 20 && acc < 4; i++) begin
      if (m_valid) begin
        chk("t1_ipc",   32'(instr_pc), 32'(acc));
        chk("t1_instr", 32'(instr),    32'(acc ^ 32'hA5A5));
        acc++;
      end
      chk("t1_wrap", 32'(wrap), 32'h0);
      step(1, acc < 4, 0, 16'h0000, m_req, 1);
    end
    chk("t1_accepts", 32'(acc), 32'd4);
    chk("t1_pc",      32'(pc),  32'h0004);

    // Wrap across FFFF
    step(1, 0, 1, 16'hFFFE, 0, 0);
    chk("t2_load_pc", 32'(pc), 32'hFFFE);
    acc = 0;
    nwrap = 0;
    for (int i = 0; i < 20 && acc < 3; i++) begin
      if (wrap) nwrap++;
      if (m_valid) begin
        exp_pc = 16'hFFFE + 16'(acc);
        chk("t2_ipc",     32'(instr_pc), 32'(exp_pc));
        chk("t2_wrap_at", 32'(wrap),     32'(instr_pc == 16'hFFFF));
        if (acc == 2) chk("t2_pc", 32'(pc), 32'h0001);
        acc++;
      end
      step(1, acc < 3, 0, 16'h0000, m_req, 1);
    end
    chk("t2_accepts", 32'(acc),   32'd3);
    chk("t2_nwrap",   32'(nwrap), 32'd1);

    // Redirect during an outstanding request
    step(1, 1, 0, 16'h0000, 0, 0);
    chk("t3_req_on", 32'(imem_req), 32'h1);
    step(1, 1, 1, 16'h0100, 0, 0);
    chk("t3_gap_req",   32'(imem_req),    32'h0);
    chk("t3_gap_valid", 32'(instr_valid), 32'h0);
    step(1, 1, 0, 16'h0000, 0, 0);
    chk("t3_req_back", 32'(imem_req),    32'h1);
    chk("t3_addr",     32'(imem_addr),   32'h0100);
    chk("t3_novalid",  32'(instr_valid), 32'h0);
    step(1, 1, 0, 16'h0000, 1, 0);
    chk("t3_ipc",   32'(instr_pc), 32'h0100);
    chk("t3_instr", 32'(instr),    32'hA4A5);

    // Decode stalls, then a redirect flushes the held word
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 16'h0000, 0, 0);
      chk("t4_instr_hold", 32'(instr),       32'hA4A5);
      chk("t4_ipc_hold",   32'(instr_pc),    32'h0100);
      chk("t4_req_low",    32'(imem_req),    32'h0);
      chk("t4_valid_hold", 32'(instr_valid), 32'h1);
    end
    step(1, 1, 1, 16'h0040, 0, 0);
    chk("t4_flush_valid", 32'(instr_valid), 32'h0);
    chk("t4_flush_addr",  32'(imem_addr),   32'h0040);
    chk("t4_flush_req",   32'(imem_req),    32'h1);
    step(1, 1, 0, 16'h0000, 1, 0);
    chk("t4_ipc", 32'(instr_pc), 32'h0040);

    // Accept with redirect, then reset mid-request at pc 7
    step(1, 1, 1, 16'h0007, 0, 1);
    chk("t5_addr", 32'(imem_addr), 32'h0007);
    chk("t5_req",  32'(imem_req),  32'h1);
`ifdef PC_FETCH_PERF_CNT_EN
    chk("t5_count", 32'(fetch_count), 32'd8);
`endif
    step(0, 1, 0, 16'h0000, 0, 0);
    chk("t5_rst_pc",    32'(pc),          32'h0);
    chk("t5_rst_req",   32'(imem_req),    32'h0);
    chk("t5_rst_valid", 32'(instr_valid), 32'h0);
    chk("t5_rst_wrap",  32'(wrap),        32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, e, l, a, rd;
      logic [15:0] la;
      r  = ($urandom_range(0, 99) >= 2);
      e  = ($urandom_range(0, 99) < 80);
      l  = ($urandom_range(0, 99) < 10);
      la = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                        : 16'($urandom);
      a  = m_req && ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 99) < 60);
      step(r, e, l, la, a, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
